// File: rtl/scan_test_ctrl.sv
// Purpose : tester-side driver for one muxed-D scan chain plus the PIs/POs of a
//           circuit under test. Patterns arrive over valid/ready. Each pattern is
//           shifted in, captured for one cycle, then unloaded and compared while
//           the next pattern shifts in. A final flush unloads the last response.
// Latency : per pattern 1 LOAD cycle (no stall) + CHAIN_LEN SHIFT + 1 CAPTURE;
//           the last pattern adds CHAIN_LEN FLUSH cycles, then one DONE cycle.
// Backpressure: pat_ready is high only in LOAD. A missing pat_valid holds the
//           controller in LOAD with SE=0, so no scan data moves.
//
// Ports:
//   CK, RST_N            clock (rising edge) and synchronous active-low reset
//   start                begins a session; honoured only in IDLE/DONE
//   pat_valid/pat_ready  pattern handshake; pat_last marks the session's final pattern
//   pat_scan             scan state to load, bit i -> flop i
//   pat_pi               primary inputs applied for capture
//   exp_po, exp_scan     expected PO at capture and expected captured chain state
//   SE, SI, SO           scan enable, serial in, serial out (flop N-1)
//   PI, PO               primary inputs driven / primary outputs observed
//   busy, done, pass     session status; done pulses once, pass holds until next start
//   fail_cnt             failing patterns (saturating)
//   first_fail           index of first failing pattern, all-ones if none
//   pat_cnt              patterns captured this session
module scan_test_ctrl #(
  parameter int CHAIN_LEN = 3,
  parameter int NUM_PI    = 4,
  parameter int NUM_PO    = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 CK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic                 pat_last,
  input  logic [CHAIN_LEN-1:0] pat_scan,
  input  logic [NUM_PI-1:0]    pat_pi,
  input  logic [NUM_PO-1:0]    exp_po,
  input  logic [CHAIN_LEN-1:0] exp_scan,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic [NUM_PI-1:0]    PI,
  input  logic [NUM_PO-1:0]    PO,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     first_fail,
  output logic [CNT_W-1:0]     pat_cnt
);

  localparam int              BW       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BW-1:0]   BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  // Shift-in data: MSB is presented on SI, register shifts left each SHIFT cycle,
  // so flop N-1's value goes out first and ends up deepest in the chain.
  logic [CHAIN_LEN-1:0]  si_sr_q, si_sr_d;
  logic                  last_q, last_d;
  logic [NUM_PO-1:0]     exp_po_q, exp_po_d;
  logic [CHAIN_LEN-1:0]  exp_scan_q, exp_scan_d;
  logic [NUM_PI-1:0]     pi_q, pi_d;
  // Response of the previously captured pattern, compared MSB-first against SO.
  logic [CHAIN_LEN-1:0]  cmp_sr_q, cmp_sr_d;
  logic                  pend_q, pend_d;
  logic                  pend_fail_q, pend_fail_d;
  logic [CNT_W-1:0]      pend_idx_q, pend_idx_d;
  logic [CNT_W-1:0]      pat_cnt_q, pat_cnt_d;
  logic [CNT_W-1:0]      fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]      first_fail_q, first_fail_d;
  logic                  pass_q, pass_d;
  logic                  done_q, done_d;

  logic                  unload_step;
  logic                  bit_bad;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    si_sr_d      = si_sr_q;
    last_d       = last_q;
    exp_po_d     = exp_po_q;
    exp_scan_d   = exp_scan_q;
    pi_d         = pi_q;
    cmp_sr_d     = cmp_sr_q;
    pend_d       = pend_q;
    pend_fail_d  = pend_fail_q;
    pend_idx_d   = pend_idx_q;
    pat_cnt_d    = pat_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    done_d       = 1'b0;
    pat_ready    = 1'b0;
    SE           = 1'b0;
    SI           = 1'b0;
    unload_step  = 1'b0;
    bit_bad      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD;
          pat_cnt_d    = '0;
          fail_cnt_d   = '0;
          first_fail_d = '1;
          pass_d       = 1'b0;
          pend_d       = 1'b0;
          pend_fail_d  = 1'b0;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        pat_ready = 1'b1;
        if (pat_valid) begin
          si_sr_d    = pat_scan;
          pi_d       = pat_pi;
          exp_po_d   = exp_po;
          exp_scan_d = exp_scan;
          last_d     = pat_last;
          bit_cnt_d  = '0;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        SE          = 1'b1;
        SI          = si_sr_q[CHAIN_LEN-1];
        si_sr_d     = si_sr_q << 1;
        unload_step = 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        // The previous response was fully unloaded in SHIFT, so the compare
        // registers are free to take this pattern's expectation.
        pat_cnt_d   = pat_cnt_q + 1'b1;
        pend_d      = 1'b1;
        pend_fail_d = (PO != exp_po_q);
        pend_idx_d  = pat_cnt_q;
        cmp_sr_d    = exp_scan_q;
        bit_cnt_d   = '0;
        state_d     = last_q ? S_FLUSH : S_LOAD;
      end

      S_FLUSH: begin
        SE          = 1'b1;
        unload_step = 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Unload compare shared by SHIFT and FLUSH. The fail flag accumulates over
    // the whole pattern so a pattern with several bad bits counts once.
    if (unload_step && pend_q) begin
      bit_bad  = (SO != cmp_sr_q[CHAIN_LEN-1]);
      cmp_sr_d = cmp_sr_q << 1;
      if (bit_cnt_q == BIT_LAST) begin
        pend_d      = 1'b0;
        pend_fail_d = 1'b0;
        if (pend_fail_q || bit_bad) begin
          if (fail_cnt_q != CNT_MAX) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
          end
          if (fail_cnt_q == '0) begin
            first_fail_d = pend_idx_q;
          end
        end
      end else begin
        pend_fail_d = pend_fail_q | bit_bad;
      end
    end

    // Verdict uses the count including the final unloaded pattern.
    if (state_q == S_FLUSH && bit_cnt_q == BIT_LAST) begin
      pass_d = (fail_cnt_d == '0);
    end
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      si_sr_q      <= '0;
      last_q       <= 1'b0;
      exp_po_q     <= '0;
      exp_scan_q   <= '0;
      pi_q         <= '0;
      cmp_sr_q     <= '0;
      pend_q       <= 1'b0;
      pend_fail_q  <= 1'b0;
      pend_idx_q   <= '0;
      pat_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '1;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      si_sr_q      <= si_sr_d;
      last_q       <= last_d;
      exp_po_q     <= exp_po_d;
      exp_scan_q   <= exp_scan_d;
      pi_q         <= pi_d;
      cmp_sr_q     <= cmp_sr_d;
      pend_q       <= pend_d;
      pend_fail_q  <= pend_fail_d;
      pend_idx_q   <= pend_idx_d;
      pat_cnt_q    <= pat_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
    end
  end

  assign PI         = pi_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                      (state_q == S_CAPTURE) || (state_q == S_FLUSH);
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;
  assign pat_cnt    = pat_cnt_q;

endmodule
